// File: rtl/rv32imc_types.sv
// rv32imc_types: shared types for the RV32 divider (op encoding, FSM states, op decode helpers)
package rv32imc_types;
   typedef enum logic [1:0] {ss_div, uu_div, ss_rem, uu_rem} div_type_t;
   typedef enum logic [1:0] {div_idle, div_calc, div_sign, div_done} div_state_t;
   // bit 1 of the op selects remainder, bit 0 selects unsigned
   function automatic logic div_is_rem(input div_type_t op);
      return op[1];
   endfunction
   function automatic logic div_is_signed(input div_type_t op);
      return !op[0];
   endfunction
endpackage

// File: rtl/rv32_div_step.sv
// rv32_div_step: one restoring-division step (combinational)
//   rem_i          partial remainder before the step
//   divisor_i      divisor magnitude
//   dividend_bit_i next dividend bit shifted into the remainder
//   rem_o          partial remainder after the step
//   q_bit_o        quotient bit produced by the step
module rv32_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             dividend_bit_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);
   logic [WIDTH+1:0] shifted, diff;
   assign shifted = {rem_i, dividend_bit_i};
   assign diff    = shifted - {2'b0, divisor_i};
   assign q_bit_o = ~diff[WIDTH+1];
   assign rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/rv32_div_unit.sv
// rv32_div_unit: iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one op in flight
//   clk, rst                   clock, synchronous active-high reset
//   flush                      kills the in-flight op
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/req_dividend/req_divisor/req_rd_addr   operation, operands, destination tag
//   resp_valid/resp_ready      response handshake (valid only in DONE)
//   resp_data/resp_rd_addr     result and echoed tag, held stable in DONE
//   busy                       unit not idle
module rv32_div_unit
   import rv32imc_types::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  div_type_t        req_op,
   input  logic [WIDTH-1:0] req_dividend,
   input  logic [WIDTH-1:0] req_divisor,
   input  logic [4:0]       req_rd_addr,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic [4:0]       resp_rd_addr,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   div_state_t state_q, state_d;
   div_type_t op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH:0] rem_q, rem_d, step_rem;
   logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, data_q, data_d;
   logic [4:0] tag_q, tag_d;
   logic neg_q_q, neg_q_d, neg_r_q, neg_r_d, step_bit, a_neg, b_neg;
   // quo_q starts as the dividend magnitude and fills with quotient bits as it shifts out
   rv32_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i(rem_q), .divisor_i(dvs_q), .dividend_bit_i(quo_q[WIDTH-1]),
      .rem_o(step_rem), .q_bit_o(step_bit)
   );
   assign a_neg = div_is_signed(req_op) && req_dividend[WIDTH-1];
   assign b_neg = div_is_signed(req_op) && req_divisor[WIDTH-1];
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      data_d  = data_q;
      tag_d   = tag_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      case (state_q)
         div_idle: if (req_valid && !flush) begin
            op_d  = req_op;
            tag_d = req_rd_addr;
            if (req_divisor == '0) begin
               data_d  = div_is_rem(req_op) ? req_dividend : '1;
               state_d = div_done;
            end else if (div_is_signed(req_op) && req_dividend == MIN_NEG && req_divisor == '1) begin
               data_d  = div_is_rem(req_op) ? '0 : MIN_NEG;
               state_d = div_done;
            end else begin
               quo_d   = a_neg ? -req_dividend : req_dividend;
               dvs_d   = b_neg ? -req_divisor : req_divisor;
               rem_d   = '0;
               cnt_d   = '0;
               neg_q_d = a_neg ^ b_neg;
               neg_r_d = a_neg;
               state_d = div_calc;
            end
         end
         div_calc: begin
            rem_d   = step_rem;
            quo_d   = {quo_q[WIDTH-2:0], step_bit};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH-1)) ? div_sign : div_calc;
         end
         div_sign: begin
            data_d  = div_is_rem(op_q) ? (neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0])
                                       : (neg_q_q ? -quo_q : quo_q);
            state_d = div_done;
         end
         div_done: state_d = resp_ready ? div_idle : div_done;
      endcase
      if (flush) state_d = div_idle;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= div_idle;
         op_q    <= ss_div;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         data_q  <= '0;
         tag_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
      end
   end
   assign req_ready    = state_q == div_idle;
   assign resp_valid   = state_q == div_done;
   assign busy         = state_q != div_idle;
   assign resp_data    = data_q;
   assign resp_rd_addr = tag_q;
endmodule

// File: tb/tb_rv32_div_unit.sv
// tb_rv32_div_unit: table-driven, corner-case and randomized checks of rv32_div_unit
module tb_rv32_div_unit;
   import rv32imc_types::*;
   logic clk = 1'b0;
   logic rst = 1'b1, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
   div_type_t req_op = uu_div;
   logic [31:0] req_dividend = '0, req_divisor = '0;
   logic [4:0] req_rd_addr = '0;
   logic req_ready, resp_valid, busy;
   logic [31:0] resp_data;
   logic [4:0] resp_rd_addr;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   rv32_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_dividend(req_dividend), .req_divisor(req_divisor), .req_rd_addr(req_rd_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd_addr(resp_rd_addr), .busy(busy)
   );
   typedef struct {
      div_type_t op;
      logic [31:0] a, b, exp;
      int lat;
   } vec_t;
   vec_t v[15];
   // RISC-V M-extension semantics written directly with SV integer arithmetic
   function automatic logic [31:0] model(input div_type_t op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      logic rm, sg;
      sa = a;
      sb = b;
      rm = (op == ss_rem) || (op == uu_rem);
      sg = (op == ss_div) || (op == ss_rem);
      if (b == 0) return rm ? a : 32'hFFFF_FFFF;
      if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
      if (sg) return rm ? 32'(sa % sb) : 32'(sa / sb);
      return rm ? a % b : a / b;
   endfunction
   function automatic int model_lat(input div_type_t op, input logic [31:0] a, input logic [31:0] b);
      logic sg;
      sg = (op == ss_div) || (op == ss_rem);
      return (b == 0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic issue(input div_type_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      req_op = op;
      req_dividend = a;
      req_divisor = b;
      req_rd_addr = tag;
      req_valid = 1'b1;
      @(posedge clk);
   endtask
   // called and returns at a negedge; hold = cycles resp_ready stays low once resp_valid is seen
   task automatic run(input div_type_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input int hold, output logic [31:0] data, output int lat);
      issue(op, a, b, tag);
      lat = 0;
      do begin
         @(negedge clk);
         if (lat == 0) begin
            req_valid = 1'b0;
            req_dividend = $urandom;
            req_divisor = $urandom;
         end
         lat++;
      end while (!resp_valid && lat < 100);
      if (!resp_valid) chk("timeout", 32'(lat), 32'd34);
      data = resp_data;
      chk("tag", 32'(resp_rd_addr), 32'(tag));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_data", resp_data, data);
         chk("hold_tag", 32'(resp_rd_addr), 32'(tag));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("ready_after_resp", 32'(req_ready), 32'd1);
   endtask
   initial begin
      logic [31:0] d;
      int lat;
      logic seen;
      v[0]  = '{uu_div, 32'd100, 32'd7, 32'd14, 34};
      v[1]  = '{uu_rem, 32'd100, 32'd7, 32'd2, 34};
      v[2]  = '{uu_div, 32'd3, 32'h10, 32'd0, 34};
      v[3]  = '{uu_rem, 32'd3, 32'h10, 32'd3, 34};
      v[4]  = '{ss_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
      v[5]  = '{ss_rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
      v[6]  = '{ss_div, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
      v[7]  = '{ss_rem, 32'd7, 32'hFFFF_FFFE, 32'd1, 34};
      v[8]  = '{ss_div, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 34};
      v[9]  = '{ss_rem, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34};
      v[10] = '{uu_div, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
      v[11] = '{uu_rem, 32'd5, 32'd0, 32'd5, 1};
      v[12] = '{ss_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      v[13] = '{ss_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
      v[14] = '{uu_div, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_rd_addr", 32'(resp_rd_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         run(v[i].op, v[i].a, v[i].b, 5'(i + 1), 0, d, lat);
         chk($sformatf("vec%0d_data", i), d, v[i].exp);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(v[i].lat));
      end
      // flush at the 10th CALC cycle
      issue(uu_div, 32'd1000, 32'd3, 5'd9);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_req_ready", 32'(req_ready), 32'd1);
      chk("flush_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= resp_valid;
      end
      chk("flush_no_resp", 32'(seen), 32'd0);
      run(uu_div, 32'hFFFF_FFFF, 32'd3, 5'd4, 0, d, lat);
      chk("post_flush_data", d, 32'h5555_5555);
      // flush together with a request in IDLE: request must be dropped
      flush = 1'b1;
      issue(uu_div, 32'd50, 32'd5, 5'd3);
      @(negedge clk);
      req_valid = 1'b0;
      flush = 1'b0;
      chk("flush_req_busy", 32'(busy), 32'd0);
      chk("flush_req_valid", 32'(resp_valid), 32'd0);
      // stalled response in DONE
      run(uu_div, 32'd1000, 32'd10, 5'd17, 5, d, lat);
      chk("stall_data", d, 32'd100);
      // reset in the middle of CALC
      issue(ss_div, 32'hFFFF_FF00, 32'd3, 5'd21);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_resp_data", resp_data, 32'd0);
      chk("midrst_rd_addr", 32'(resp_rd_addr), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      // randomized sweep
      for (int i = 0; i < 60; i++) begin
         div_type_t op;
         logic [31:0] a, b;
         op = div_type_t'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 20);
            3: b = -$urandom_range(1, 20);
            4: a = $urandom_range(0, 100);
            default: ;
         endcase
         run(op, a, b, 5'($urandom), 0, d, lat);
         chk($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), d, model(op, a, b));
         chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_lat(op, a, b)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
